// File: rtl/cycle_sequencer.sv
// cycle_sequencer: picks the next timing-cycle step (advance, skip or end)
// for the instruction/cycle controller. It also accepts interrupts at
// instruction boundaries and runs the post-reset and interrupt BRK sequences.
module cycle_sequencer #(
    parameter int MAXCYC = 6
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] ir_i,
    input  logic [2:0] cycle_i,
    input  logic       sync_i,
    input  logic       rdy_i,
    input  logic       irqReq_i,
    input  logic       nmiReq_i,
    input  logic       iFlag_i,
    input  logic       pageCross_i,
    input  logic       branchTaken_i,
    output logic       iCyc_o,
    output logic       sCyc_o,
    output logic       rCyc_o,
    output logic       irq_o,
    output logic       rstOut_o,
    output logic [1:0] vecSel_o,
    output logic       isInt_o,
    output logic       wrInhibit_o
);

    localparam logic [1:0] RESET  = 2'b00;
    localparam logic [1:0] RSTSEQ = 2'b01;
    localparam logic [1:0] RUN    = 2'b10;
    localparam logic [1:0] INTSEQ = 2'b11;

    // Last cycle of the forced BRK used by the reset and interrupt sequences
    localparam logic [2:0] SeqLast = 3'(MAXCYC);

    localparam logic [1:0] VecIrq = 2'b00;
    localparam logic [1:0] VecNmi = 2'b01;
    localparam logic [1:0] VecRst = 2'b10;

    logic [1:0] state_q, state_d;
    logic       nmiPend_q, nmiPend_d;
    logic       nmiPrev_q;
    logic [1:0] vecLatch_q, vecLatch_d;

    logic [2:0] opLen;
    logic       idxRead;
    logic       isBranch;
    logic [2:0] lastCyc;
    logic       nmiEdge;
    logic       active;

    // The controller already tracks opcode-latch timing, so sync is not needed here
    logic unusedSync;
    assign unusedSync = sync_i;

    assign nmiEdge  = nmiReq_i & ~nmiPrev_q;
    assign isBranch = (ir_i[4:0] == 5'b10000);
    assign active   = ~rst_i & (state_q != RESET);

    // NMOS 6502 instruction length; indexed reads list their full page-cross length
    always_comb begin
        opLen   = 3'd2;
        idxRead = 1'b0;
        case (ir_i)
            8'h00, 8'h1E, 8'h3E, 8'h5E, 8'h7E, 8'hDE, 8'hFE:
                opLen = 3'd7;
            8'h11, 8'h31, 8'h51, 8'h71, 8'hB1, 8'hD1, 8'hF1: begin
                opLen   = 3'd6;
                idxRead = 1'b1;
            end
            8'h01, 8'h21, 8'h41, 8'h61, 8'h81, 8'hA1, 8'hC1, 8'hE1,
            8'h0E, 8'h2E, 8'h4E, 8'h6E, 8'hCE, 8'hEE,
            8'h16, 8'h36, 8'h56, 8'h76, 8'hD6, 8'hF6,
            8'h20, 8'h40, 8'h60, 8'h91:
                opLen = 3'd6;
            8'h19, 8'h39, 8'h59, 8'h79, 8'hB9, 8'hD9, 8'hF9,
            8'h1D, 8'h3D, 8'h5D, 8'h7D, 8'hBD, 8'hDD, 8'hFD,
            8'hBC, 8'hBE: begin
                opLen   = 3'd5;
                idxRead = 1'b1;
            end
            8'h06, 8'h26, 8'h46, 8'h66, 8'hC6, 8'hE6,
            8'h6C, 8'h99, 8'h9D:
                opLen = 3'd5;
            8'h0D, 8'h2D, 8'h4D, 8'h6D, 8'h8D, 8'hAD, 8'hCD, 8'hED,
            8'h2C, 8'h8C, 8'hAC, 8'hCC, 8'hEC, 8'h8E, 8'hAE,
            8'h15, 8'h35, 8'h55, 8'h75, 8'h95, 8'hB5, 8'hD5, 8'hF5,
            8'h94, 8'hB4, 8'h96, 8'hB6, 8'h28, 8'h68:
                opLen = 3'd4;
            8'h05, 8'h25, 8'h45, 8'h65, 8'h85, 8'hA5, 8'hC5, 8'hE5,
            8'h24, 8'h84, 8'hA4, 8'hC4, 8'hE4, 8'h86, 8'hA6,
            8'h08, 8'h48, 8'h4C:
                opLen = 3'd3;
            default:
                opLen = 3'd2;
        endcase
    end

    // Cycle step: cycle 0 always advances, branches resolve early, clean indexed reads skip the fixup
    always_comb begin
        iCyc_o  = 1'b0;
        sCyc_o  = 1'b0;
        rCyc_o  = 1'b0;
        lastCyc = (state_q == RUN) ? (opLen - 3'd1) : SeqLast;
        if (active && rdy_i) begin
            if (cycle_i == 3'd0) begin
                iCyc_o = 1'b1;
            end else if ((state_q == RUN) && isBranch) begin
                case (cycle_i)
                    3'd1:    begin iCyc_o = branchTaken_i; rCyc_o = ~branchTaken_i; end
                    3'd2:    begin iCyc_o = pageCross_i;   rCyc_o = ~pageCross_i;   end
                    default: rCyc_o = 1'b1;
                endcase
            end else if (cycle_i >= lastCyc) begin
                rCyc_o = 1'b1;
            end else if ((state_q == RUN) && idxRead &&
                         (cycle_i == (lastCyc - 3'd2)) && !pageCross_i) begin
                sCyc_o = 1'b1;
            end else begin
                iCyc_o = 1'b1;
            end
        end
    end

    // Sequence-level controls follow the FSM state and are forced quiet while reset is asserted
    always_comb begin
        rstOut_o    = rst_i | (state_q == RESET);
        irq_o       = active & ((state_q == RSTSEQ) | (state_q == INTSEQ)) & (cycle_i == 3'd0);
        isInt_o     = active & (state_q == INTSEQ);
        wrInhibit_o = active & (state_q == RSTSEQ);
        vecSel_o    = VecRst;
        if (active) begin
            case (state_q)
                INTSEQ:  vecSel_o = vecLatch_q;
                RUN:     vecSel_o = VecIrq;
                default: vecSel_o = VecRst;
            endcase
        end
    end

    // Interrupts are only accepted on the final cycle of a RUN instruction; NMI wins over IRQ
    always_comb begin
        state_d    = state_q;
        vecLatch_d = vecLatch_q;
        nmiPend_d  = nmiPend_q | nmiEdge;
        case (state_q)
            RESET: state_d = RSTSEQ;
            RUN: begin
                if (rCyc_o) begin
                    if (nmiPend_q | nmiEdge) begin
                        state_d    = INTSEQ;
                        vecLatch_d = VecNmi;
                        nmiPend_d  = 1'b0;
                    end else if (irqReq_i & ~iFlag_i) begin
                        state_d    = INTSEQ;
                        vecLatch_d = VecIrq;
                    end
                end
            end
            default: begin
                if (rCyc_o) begin
                    state_d = RUN;
                end
            end
        endcase
        if (!rdy_i) begin
            state_d    = state_q;
            vecLatch_d = vecLatch_q;
        end
    end

    // State registers; NMI edge history keeps sampling even while rdy stalls the sequence
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RESET;
            nmiPend_q  <= 1'b0;
            nmiPrev_q  <= 1'b0;
            vecLatch_q <= VecRst;
        end else begin
            state_q    <= state_d;
            nmiPend_q  <= nmiPend_d;
            nmiPrev_q  <= nmiReq_i;
            vecLatch_q <= vecLatch_d;
        end
    end

endmodule
